// File: rtl/lif_array.sv
// lif_array: N leaky integrate-and-fire neurons time-multiplexed over one
// update datapath. Each accepted step sweeps neurons 0..N-1, one per clock,
// then publishes the spike vector with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for step; outputs hold the last sweep's spikes
// SWEEP  | updating neuron idx_q this cycle
module lif_array #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT_W  = 3,
  localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step,
  input  logic [N_NEURONS*WIDTH-1:0]   current,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [REFRACT_W-1:0]         refract_period,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spikes,
  input  logic [IDX_W-1:0]             state_sel,
  output logic [WIDTH-1:0]             state_out
);

  typedef enum logic {S_IDLE, S_SWEEP} fsm_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W:0]   N_COUNT  = (IDX_W + 1)'(N_NEURONS);

  fsm_t                   fsm_q, fsm_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       thr_q, thr_d;
  logic [REFRACT_W-1:0]   rper_q, rper_d;
  logic [WIDTH-1:0]       cur_q [N_NEURONS];
  logic [WIDTH-1:0]       cur_d [N_NEURONS];
  logic [WIDTH-1:0]       mem_q [N_NEURONS];
  logic [WIDTH-1:0]       mem_d [N_NEURONS];
  logic [REFRACT_W-1:0]   ref_q [N_NEURONS];
  logic [REFRACT_W-1:0]   ref_d [N_NEURONS];
  logic [N_NEURONS-1:0]   acc_q, acc_d;
  logic [N_NEURONS-1:0]   spikes_q, spikes_d;
  logic                   done_q, done_d;

  logic [WIDTH-1:0]       cur_sel, mem_sel, leaked, v_sat;
  logic [REFRACT_W-1:0]   ref_sel;
  logic [WIDTH:0]         sum;
  logic                   refractory, fire;

  // Shared datapath: leak, integrate with saturation, threshold compare.
  always_comb begin
    cur_sel    = cur_q[idx_q];
    mem_sel    = mem_q[idx_q];
    ref_sel    = ref_q[idx_q];
    leaked     = mem_sel >> LEAK_SHIFT;
    sum        = {1'b0, cur_sel} + {1'b0, leaked};
    v_sat      = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    refractory = (ref_sel != '0);
    fire       = !refractory && (v_sat >= thr_q);
  end

  // Next-state logic for the sweep FSM and per-neuron storage.
  always_comb begin
    fsm_d    = fsm_q;
    idx_d    = idx_q;
    thr_d    = thr_q;
    rper_d   = rper_q;
    acc_d    = acc_q;
    spikes_d = spikes_q;
    done_d   = 1'b0;
    for (int i = 0; i < N_NEURONS; i++) begin
      cur_d[i] = cur_q[i];
      mem_d[i] = mem_q[i];
      ref_d[i] = ref_q[i];
    end

    case (fsm_q)
      S_IDLE: begin
        if (step) begin
          fsm_d  = S_SWEEP;
          idx_d  = '0;
          thr_d  = threshold;
          rper_d = refract_period;
          acc_d  = '0;
          for (int i = 0; i < N_NEURONS; i++) begin
            cur_d[i] = current[i*WIDTH +: WIDTH];
          end
        end
      end
      S_SWEEP: begin
        if (refractory) begin
          mem_d[idx_q] = '0;
          ref_d[idx_q] = ref_sel - REFRACT_W'(1);
        end else if (fire) begin
          mem_d[idx_q] = '0;
          ref_d[idx_q] = rper_q;
        end else begin
          mem_d[idx_q] = v_sat;
        end
        acc_d[idx_q] = fire;
        if (idx_q == LAST_IDX) begin
          // Publish all spike bits together, including the neuron just updated.
          fsm_d    = S_IDLE;
          spikes_d = acc_d;
          done_d   = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any partially completed sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= S_IDLE;
      idx_q    <= '0;
      thr_q    <= '0;
      rper_q   <= '0;
      acc_q    <= '0;
      spikes_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        cur_q[i] <= '0;
        mem_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      fsm_q    <= fsm_d;
      idx_q    <= idx_d;
      thr_q    <= thr_d;
      rper_q   <= rper_d;
      acc_q    <= acc_d;
      spikes_q <= spikes_d;
      done_q   <= done_d;
      for (int i = 0; i < N_NEURONS; i++) begin
        cur_q[i] <= cur_d[i];
        mem_q[i] <= mem_d[i];
        ref_q[i] <= ref_d[i];
      end
    end
  end

  // Output decode; out-of-range debug indices read as zero.
  always_comb begin
    busy      = (fsm_q == S_SWEEP);
    done      = done_q;
    spikes    = spikes_q;
    state_out = '0;
    if ({1'b0, state_sel} < N_COUNT) begin
      state_out = mem_q[state_sel];
    end
  end

endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        step;
  logic [31:0] current;
  logic [7:0]  threshold;
  logic [2:0]  refract_period;
  logic        busy;
  logic        done;
  logic [3:0]  spikes;
  logic [1:0]  state_sel;
  logic [7:0]  state_out;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  lif_array #(.N_NEURONS(N), .WIDTH(8), .LEAK_SHIFT(1), .REFRACT_W(3)) dut (
    .clk(clk), .reset(reset), .step(step), .current(current),
    .threshold(threshold), .refract_period(refract_period),
    .busy(busy), .done(done), .spikes(spikes),
    .state_sel(state_sel), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected spike vector.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with spikes %b, expected no done", spikes);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        if (spikes !== e) begin
          errors++;
          $display("FAIL spikes: got %b expected %b", spikes, e);
        end
      end
    end
  end

  task automatic check_states(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < N; i++) begin
      state_sel = 2'(i);
      #1;
      chk($sformatf("%s_state%0d", name, i), {24'd0, state_out}, {24'd0, e[i]});
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One sweep: issue step, push expectation, check busy and done latency.
  task automatic run_step(input logic [31:0] cur, input logic [7:0] thr, input logic [2:0] rp,
                          input logic [3:0] exp_spk, input bit poke, input bit scramble);
    int k;
    @(negedge clk);
    current = cur; threshold = thr; refract_period = rp; step = 1'b1;
    sb.push_back(exp_spk);
    @(negedge clk);
    step = 1'b0;
    chk("busy_after_step", {31'd0, busy}, 32'd1);
    if (scramble) begin
      current = 32'hFFFF_FFFF; threshold = 8'd0; refract_period = 3'd7;
    end
    k = 1;
    while (!done && k <= 3 * N + 4) begin
      step = (poke && k == 2);
      @(negedge clk);
      k++;
    end
    step = 1'b0;
    chk("done_latency", k, N + 1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b1; step = 1'b0; current = '0; threshold = '0;
    refract_period = '0; state_sel = '0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_spikes", {28'd0, spikes}, 32'd0);
    check_states("reset", 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Integration and leak
    run_step(32'h05050505, 8, 0, 4'b0000, 0, 0); check_states("int1", 5, 5, 5, 5);
    run_step(32'h05050505, 8, 0, 4'b0000, 0, 0); check_states("int2", 7, 7, 7, 7);
    run_step(32'h05050505, 8, 0, 4'b1111, 0, 0); check_states("int3", 0, 0, 0, 0);
    run_step(32'h03030303, 8, 0, 4'b0000, 0, 0); check_states("sub1", 3, 3, 3, 3);
    run_step(32'h03030303, 8, 0, 4'b0000, 0, 0); check_states("sub2", 4, 4, 4, 4);
    run_step(32'h03030303, 8, 0, 4'b0000, 0, 0); check_states("sub3", 5, 5, 5, 5);
    run_step(32'h03030303, 8, 0, 4'b0000, 0, 0); check_states("sub4", 5, 5, 5, 5);

    // Saturation
    run_step(32'hFFFFFFFF, 255, 0, 4'b1111, 0, 0); check_states("sat1", 0, 0, 0, 0);
    run_step(32'hC8C8C8C8, 255, 0, 4'b0000, 0, 0); check_states("sat2", 200, 200, 200, 200);
    run_step(32'hC8C8C8C8, 255, 0, 4'b1111, 0, 0); check_states("sat3", 0, 0, 0, 0);

    // Refractory period of 2
    apply_reset();
    run_step(32'hC8C8C8C8, 8, 2, 4'b1111, 0, 0); check_states("ref1", 0, 0, 0, 0);
    run_step(32'hC8C8C8C8, 8, 2, 4'b0000, 0, 0); check_states("ref2", 0, 0, 0, 0);
    run_step(32'hC8C8C8C8, 8, 2, 4'b0000, 0, 0); check_states("ref3", 0, 0, 0, 0);
    run_step(32'hC8C8C8C8, 8, 2, 4'b1111, 0, 0); check_states("ref4", 0, 0, 0, 0);

    // Mixed channels, inputs scrambled while busy
    apply_reset();
    run_step({8'd255, 8'd4, 8'd8, 8'd0}, 8, 0, 4'b1010, 0, 1); check_states("mix1", 0, 0, 4, 0);
    run_step(32'h00000000, 8, 0, 4'b0000, 0, 0); check_states("mix2", 0, 0, 2, 0);
    run_step(32'h00000000, 0, 0, 4'b1111, 0, 0); check_states("thr0", 0, 0, 0, 0);

    // Step pulsed while busy must be ignored
    apply_reset();
    run_step(32'h05050505, 8, 0, 4'b0000, 1, 0); check_states("poke", 5, 5, 5, 5);
    repeat (3 * N) @(negedge clk);

    // Step held high: back-to-back sweeps every N+1 cycles
    @(negedge clk);
    current = 32'h05050505; threshold = 8; refract_period = 0; step = 1'b1;
    sb.push_back(4'b0000);
    sb.push_back(4'b1111);
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("b2b_first_latency", k, N + 1);
    @(negedge clk);
    step = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    k = 1;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("b2b_period", k, N + 1);
    check_states("b2b", 0, 0, 0, 0);

    // Asynchronous reset mid-sweep
    apply_reset();
    run_step({8'd255, 8'd4, 8'd8, 8'd0}, 8, 0, 4'b1010, 0, 0);
    @(negedge clk);
    current = 32'h64646464; threshold = 255; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_spikes", {28'd0, spikes}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_states("abort", 0, 0, 0, 0);
    repeat (3 * N) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath. Each `step` strobe advances every neuron by one timestep, one neuron per clock. Threshold and refractory period are programmable at run time; leak and sizes are parameters. It sits between the stimulus/current generator and the spike-output logic and scales the single-neuron LIF cell to N channels, adding saturation, refractoriness and a start/done handshake.

## Interface
- `N_NEURONS`, default 4: number of neurons (≥1).
- `WIDTH`, default 8: membrane state, current and threshold width in bits.
- `LEAK_SHIFT`, default 1: decay as a right shift of state per step (0 = no leak).
- `REFRACT_W`, default 3: width of the refractory counter and period input.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `step`  in  1  request one timestep sweep; accepted only when `busy`=0.
- `current`  in  N_NEURONS*WIDTH  packed input currents, neuron i at `[i*WIDTH +: WIDTH]`, unsigned.
- `threshold`  in  WIDTH  spike threshold, unsigned.
- `refract_period`  in  REFRACT_W  steps a neuron is held at 0 after spiking.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse: sweep complete, `spikes` updated.
- `spikes`  out  N_NEURONS  spike flags from the last completed sweep; held until next `done`.
- `state_sel`  in  clog2(N_NEURONS) (min 1)  debug neuron index.
- `state_out`  out  WIDTH  membrane state of neuron `state_sel` (combinational read of stored state).

## Operation
- Per-neuron storage: `state_i` (WIDTH), `ref_i` (REFRACT_W), spike accumulator bit.
- On accepted `step`: latch `current`, `threshold`, `refract_period` into internal registers; index ← 0; `busy` ← 1. Inputs may change afterwards.
- FSM: IDLE → SWEEP (N_NEURONS cycles, index 0..N-1) → IDLE with `done` pulse. Step ignored while not IDLE.
- Update of neuron i in SWEEP:
  - if `ref_i` ≠ 0: `state_i` ← 0, `ref_i` ← `ref_i`−1, spike_i = 0.
  - else v = sat_WIDTH(`current_i` + (`state_i` >> LEAK_SHIFT)), sum computed at WIDTH+1 bits, clamped to 2^WIDTH−1.
  - if v ≥ `threshold`: spike_i = 1, `state_i` ← 0, `ref_i` ← `refract_period`; else spike_i = 0, `state_i` ← v.
- After neuron N−1: `spikes` ← accumulated vector (all bits at once), `done` pulses.
- `threshold` = 0: every non-refractory neuron spikes each step.
- `refract_period` = 0: no refractory hold.

## Timing
- Reset values: `busy`=0, `done`=0, `spikes`=0; all `state_i`=0, `ref_i`=0; FSM IDLE. Asserting `reset` mid-sweep aborts immediately: no `done`, partial updates discarded (states all 0).
- `step` high in cycle T with `busy`=0 → `busy`=1 in cycles T+1..T+N; neuron k written at the end of cycle T+1+k.
- `done`=1 and new `spikes` visible in cycle T+N+1; `busy`=0 in that cycle.
- `step` asserted in the `done` cycle is accepted (back-to-back sweeps, period N+1 cycles).
- `step` held high continuously → one sweep per N+1 cycles.
- `state_out` reflects writes the cycle after each neuron's update edge.

## Test plan
- Reset: assert `reset` asynchronously mid-sweep (N=4, WIDTH=8) → `busy`,`done`,`spikes` drop to 0 without a clock edge; no `done` afterwards; all `state_out` = 0.
- Integration/leak: threshold=8, refract=0, all currents=5 → states 5, 7, then v=8 spikes on 3rd step: `spikes`=4'b1111 with 3rd `done`, states 0; currents=3 → states 3,4,5,5,5…, never spike.
- Saturation: threshold=255, current=255 → first step v=255 → spike; threshold=255, current=200 then 200 → 200, then sat(200+100)=255 → spike on 2nd step.
- Refractory: refract=2, threshold=8, current=200 every step → spikes on steps 1,4,7…; state_out=0 on steps 2,3.
- Handshake: `step` pulsed while `busy` → ignored (exactly one `done`); `step` in `done` cycle → next `busy` next cycle; `done` exactly N+1 cycles after accepted `step`.
- Mixed channels: currents {0,8,4,255}, threshold=8 → `spikes`=4'b1010 after 1st step; input changes during `busy` do not affect result.
